// File: rtl/irq_pkg.sv
// Interrupt controller shared types and constants.
// Also used by the MMIO interrupt register block.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    ISR   = 2'd2,
    EXIT  = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_IRQ_DEF    = 8;
  localparam int ID_BITS_DEF    = 3;

  localparam logic [31:0] MMIO_IRQ_TRIG = 32'hFFFF_0040;
  localparam logic [31:0] MMIO_IRQ_PC   = 32'hFFFF_0044;

  function automatic logic [31:0] align_word(
    input logic [31:0] pc
  );
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bundle between MMIO irq registers, retire stage
// and fetch redirect for the interrupt controller.
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IRQ    = NUM_IRQ_DEF,
  parameter int ID_BITS    = ID_BITS_DEF
);

  logic                  stall;
  logic [DATA_WIDTH-1:0] trigger;
  logic [DATA_WIDTH-1:0] handler_pc;
  logic                  int_enable;
  logic                  retire_valid;
  logic [DATA_WIDTH-1:0] retire_pc;
  logic                  iret;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] epc;
  logic [ID_BITS-1:0]    cause_id;
  logic                  in_isr;
  logic [NUM_IRQ-1:0]    pending;

  modport master (
    output stall, trigger, handler_pc,
    output int_enable, retire_valid,
    output retire_pc, iret,
    input  redirect_valid, redirect_pc,
    input  epc, cause_id, in_isr, pending
  );

  modport slave (
    input  stall, trigger, handler_pc,
    input  int_enable, retire_valid,
    input  retire_pc, iret,
    output redirect_valid, redirect_pc,
    output epc, cause_id, in_isr, pending
  );

endinterface

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest pending index wins.
module irq_priority_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_BITS = 3
) (
  input  logic [NUM_IRQ-1:0] pending,
  output logic [ID_BITS-1:0] sel_id,
  output logic               sel_valid
);

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = ID_BITS'(i);
    end
  end

  assign sel_valid = |pending;

endmodule

// File: rtl/irq_controller.sv
// Latches irq triggers, saves resume PC and
// redirects fetch into and out of the handler.
module irq_controller
  import irq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IRQ    = NUM_IRQ_DEF,
  parameter int ID_BITS    = ID_BITS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  irq_controller_if.slave  bus
);

  localparam int DW = DATA_WIDTH;

  state_t             state;
  logic [DW-1:0]      target;
  logic [DW-1:0]      epc_q;
  logic [ID_BITS-1:0] cause_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] trig;
  logic [NUM_IRQ-1:0] clr;
  logic [ID_BITS-1:0] sel_id;
  logic               sel_valid;
  logic               take;
  logic               unused_bits;

  irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_BITS (ID_BITS)
  ) u_enc (
    .pending   (pend_q),
    .sel_id    (sel_id),
    .sel_valid (sel_valid)
  );

  assign trig = bus.trigger[NUM_IRQ-1:0];

  generate
    if (NUM_IRQ < DW) begin : g_hi
      assign unused_bits = ^{bus.trigger[DW-1:NUM_IRQ],
                             bus.handler_pc[1:0]};
    end else begin : g_nohi
      assign unused_bits = ^bus.handler_pc[1:0];
    end
  endgenerate

  assign take = (state == IDLE) && sel_valid &&
                bus.int_enable && bus.retire_valid &&
                !bus.stall;

  assign clr = take ? (NUM_IRQ'(1) << sel_id) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      target  <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      pend_q  <= '0;
    end else begin
      // New trigger beats the clear of the bit being taken.
      pend_q <= (pend_q & ~clr) | trig;
      unique case (state)
        IDLE: begin
          if (take) begin
            epc_q   <= bus.retire_pc;
            cause_q <= sel_id;
            target  <= {bus.handler_pc[DW-1:2], 2'b00};
            state   <= ENTER;
          end
        end
        ENTER: if (!bus.stall) state <= ISR;
        ISR: if (bus.iret && !bus.stall) state <= EXIT;
        EXIT: if (!bus.stall) state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = (state == ENTER) ||
                              (state == EXIT);
  assign bus.redirect_pc = (state == ENTER) ? target :
                           (state == EXIT)  ? epc_q  :
                           '0;
  assign bus.in_isr   = (state == ISR);
  assign bus.epc      = epc_q;
  assign bus.cause_id = cause_q;
  assign bus.pending  = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
module tb_irq_controller;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clock = ~clock;

  irq_controller_if #(
    .DATA_WIDTH (32),
    .NUM_IRQ    (8),
    .ID_BITS    (3)
  ) bus ();

  irq_controller #(
    .DATA_WIDTH (32),
    .NUM_IRQ    (8),
    .ID_BITS    (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic        rv,
    input logic [31:0] rpc,
    input logic        isr
  );
    check({tag, ".rv"}, 32'(bus.redirect_valid), 32'(rv));
    check({tag, ".rpc"}, bus.redirect_pc, rpc);
    check({tag, ".isr"}, 32'(bus.in_isr), 32'(isr));
  endtask

  // From ENTER with stall low: ISR, EXIT, back to IDLE.
  task automatic finish_isr(input string tag);
    step();
    chk_out({tag, ".isr"}, 1'b0, 32'h0, 1'b1);
    bus.iret = 1'b1;
    step();
    bus.iret = 1'b0;
    chk_out({tag, ".exit"}, 1'b1, bus.epc, 1'b0);
    step();
    chk_out({tag, ".idle"}, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.stall        = 1'b0;
    bus.trigger      = '0;
    bus.handler_pc   = '0;
    bus.int_enable   = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_pc    = '0;
    bus.iret         = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_out("rst", 1'b0, 32'h0, 1'b0);
    check("rst.epc", bus.epc, 32'h0);
    check("rst.cause", 32'(bus.cause_id), 32'h0);
    check("rst.pend", 32'(bus.pending), 32'h0);

    // Basic take
    bus.handler_pc   = 32'h400;
    bus.int_enable   = 1'b1;
    bus.retire_valid = 1'b1;
    bus.retire_pc    = 32'h100;
    bus.trigger      = 32'h4;
    step();
    bus.trigger = '0;
    check("basic.pend1", 32'(bus.pending), 32'h4);
    check("basic.norv", 32'(bus.redirect_valid), 32'h0);
    step();
    check("basic.epc", bus.epc, 32'h100);
    check("basic.cause", 32'(bus.cause_id), 32'h2);
    check("basic.pend0", 32'(bus.pending), 32'h0);
    chk_out("basic.enter", 1'b1, 32'h400, 1'b0);
    finish_isr("basic");
    check("basic.epc_hold", bus.epc, 32'h100);

    // Priority
    bus.retire_pc = 32'h200;
    bus.trigger   = 32'h0A;
    step();
    bus.trigger = '0;
    check("prio.pend", 32'(bus.pending), 32'h0A);
    step();
    check("prio.cause", 32'(bus.cause_id), 32'h1);
    check("prio.pend8", 32'(bus.pending), 32'h08);
    check("prio.epc", bus.epc, 32'h200);
    step();
    bus.iret = 1'b1;
    step();
    bus.iret = 1'b0;
    chk_out("prio.exit", 1'b1, 32'h200, 1'b0);
    step();
    chk_out("prio.idle", 1'b0, 32'h0, 1'b0);
    check("prio.pend_keep", 32'(bus.pending), 32'h08);
    step();
    check("prio.cause3", 32'(bus.cause_id), 32'h3);
    check("prio.pend_clr", 32'(bus.pending), 32'h0);
    chk_out("prio.enter3", 1'b1, 32'h400, 1'b0);
    finish_isr("prio3");

    // Stall hold, unaligned handler address
    bus.handler_pc = 32'h403;
    bus.trigger    = 32'h20;
    step();
    bus.trigger = '0;
    step();
    bus.stall = 1'b1;
    check("stall.cause", 32'(bus.cause_id), 32'h5);
    chk_out("stall.enter", 1'b1, 32'h400, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("stall.hold%0d", i),
              1'b1, 32'h400, 1'b0);
    end
    bus.stall = 1'b0;
    finish_isr("stall");

    // Masking and no nesting
    bus.int_enable = 1'b0;
    bus.trigger    = 32'h1;
    step();
    bus.trigger = '0;
    step();
    step();
    check("mask.pend", 32'(bus.pending), 32'h1);
    chk_out("mask.none", 1'b0, 32'h0, 1'b0);
    bus.int_enable = 1'b1;
    bus.retire_pc  = 32'h300;
    step();
    bus.int_enable = 1'b0;
    check("mask.cause", 32'(bus.cause_id), 32'h0);
    chk_out("mask.enter", 1'b1, 32'h400, 1'b0);
    step();
    bus.trigger = 32'h2;
    step();
    bus.trigger = '0;
    check("nest.pend", 32'(bus.pending), 32'h2);
    chk_out("nest.isr", 1'b0, 32'h0, 1'b1);
    step();
    chk_out("nest.isr2", 1'b0, 32'h0, 1'b1);
    bus.iret = 1'b1;
    step();
    bus.iret = 1'b0;
    chk_out("nest.exit", 1'b1, 32'h300, 1'b0);
    step();
    chk_out("nest.idle", 1'b0, 32'h0, 1'b0);
    bus.int_enable = 1'b1;
    step();
    check("nest.cause1", 32'(bus.cause_id), 32'h1);
    finish_isr("nest");

    // Set wins over clear
    bus.trigger = 32'h4;
    step();
    step();
    bus.trigger = '0;
    check("setwin.cause", 32'(bus.cause_id), 32'h2);
    check("setwin.pend", 32'(bus.pending), 32'h4);
    finish_isr("setwin");

    // Reset mid-ISR; upper trigger bits ignored
    step();
    check("rsti.cause", 32'(bus.cause_id), 32'h2);
    step();
    bus.trigger = 32'h0000_0110;
    step();
    bus.trigger = '0;
    check("rsti.pend", 32'(bus.pending), 32'h10);
    chk_out("rsti.isr", 1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("rsti.out", 1'b0, 32'h0, 1'b0);
    check("rsti.epc", bus.epc, 32'h0);
    check("rsti.cause0", 32'(bus.cause_id), 32'h0);
    check("rsti.pend0", 32'(bus.pending), 32'h0);
    bus.iret = 1'b1;
    step();
    bus.iret = 1'b0;
    chk_out("rsti.iret", 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
